md_ctrl: RTL and testbench

Sequencing controller for the shared multiply/divide unit, sitting beside the EX stage of the five-stage pipeline. It decodes the EX-stage HI/LO-class operation into the unit's start/op/mthi/mtlo controls and holds off ID-stage HI/LO instructions while a multiply or divide is in flight. It tracks the unit's busy window against the expected latency and reports a one-cycle completion pulse and a sticky protocol-error flag.

---
 rtl/md_ctrl.sv | 115 +++++++++++
 tb/tb_md_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_ctrl.sv
// md_ctrl - sequencing controller for the shared multiply/divide unit.
//
// Decodes the EX-stage HI/LO-class op into unit start/op/mthi/mtlo controls,
// holds off ID-stage HI/LO instructions while the unit is busy, and watches
// the unit's busy window against the expected latency.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   ex_valid     EX stage holds a real instruction
//   ex_md_op     EX HI/LO class (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none)
//   id_uses_md   ID-stage instruction is a HI/LO-class op
//   md_busy      busy flag from the unit
//   md_start     start strobe to the unit
//   md_op        unit op: 00 mult, 01 multu, 10 div, 11 divu
//   md_mthi/mtlo write HI/LO from operand A
//   hilo_sel     EX read-back select: 0 HI, 1 LO
//   stall_id     freeze PC/IF/ID, bubble into EX
//   md_done      one-cycle completion pulse
//   proto_err    sticky protocol-error flag
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no operation in flight; unit expected idle
// ST_BUSY | operation started; counting busy cycles until md_busy drops
module md_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_valid,
  input  logic [3:0] ex_md_op,
  input  logic       id_uses_md,
  input  logic       md_busy,
  output logic       md_start,
  output logic [1:0] md_op,
  output logic       md_mthi,
  output logic       md_mtlo,
  output logic       hilo_sel,
  output logic       stall_id,
  output logic       md_done,
  output logic       proto_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

  logic [0:0]       st;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] exp_lat;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       op_m1;
  logic             is_mul;
  logic             is_div;
  logic             is_unit_op;
  logic             is_hilo_write;
  logic             blocked;
  logic             over_lat;
  logic             err_set;

  always_comb begin
    is_mul        = (ex_md_op == 4'd1) || (ex_md_op == 4'd2);
    is_div        = (ex_md_op == 4'd3) || (ex_md_op == 4'd4);
    is_unit_op    = is_mul || is_div;
    is_hilo_write = (ex_md_op >= 4'd1) && (ex_md_op <= 4'd6);
    // Unit is mid-operation: nothing new may be issued to it.
    blocked       = (st == ST_BUSY) && md_busy;

    md_start = ex_valid && is_unit_op && !blocked;
    op_m1    = ex_md_op - 4'd1;
    md_op    = is_unit_op ? op_m1[1:0] : 2'b00;
    md_mthi  = ex_valid && (ex_md_op == 4'd5) && !blocked;
    md_mtlo  = ex_valid && (ex_md_op == 4'd6) && !blocked;
    hilo_sel = (ex_md_op == 4'd8);
    stall_id = id_uses_md && (md_start || blocked);
    md_done  = (st == ST_BUSY) && !md_busy;

    cnt_inc  = (&cnt) ? cnt : cnt + CNT_W'(1);
    // One extra bit so the compare stays correct when cnt is saturated.
    over_lat = ({1'b0, cnt} + (CNT_W+1)'(1)) > {1'b0, exp_lat};

    err_set = ((st == ST_IDLE) && md_busy)
           || (blocked && ex_valid && is_hilo_write)
           || (blocked && over_lat)
           || (md_done && (cnt != exp_lat));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= ST_IDLE;
      cnt       <= '0;
      exp_lat   <= '0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= proto_err | err_set;
      // md_start can only be high when idle or in the done cycle, so a
      // start in the done cycle reloads the window with no idle gap.
      if (md_start) begin
        st      <= ST_BUSY;
        cnt     <= '0;
        exp_lat <= is_mul ? MULT_CNT : DIV_CNT;
      end else if (md_done) begin
        st <= ST_IDLE;
      end else if (blocked) begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
module tb_md_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ex_valid;
  logic [3:0] ex_md_op;
  logic       id_uses_md;
  logic       md_busy;
  logic       md_start;
  logic [1:0] md_op;
  logic       md_mthi;
  logic       md_mtlo;
  logic       hilo_sel;
  logic       stall_id;
  logic       md_done;
  logic       proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  md_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .ex_valid   (ex_valid),
    .ex_md_op   (ex_md_op),
    .id_uses_md (id_uses_md),
    .md_busy    (md_busy),
    .md_start   (md_start),
    .md_op      (md_op),
    .md_mthi    (md_mthi),
    .md_mtlo    (md_mtlo),
    .hilo_sel   (hilo_sel),
    .stall_id   (stall_id),
    .md_done    (md_done),
    .proto_err  (proto_err)
  );

  task automatic drive(input logic v, input logic [3:0] op, input logic id, input logic b);
    ex_valid   = v;
    ex_md_op   = op;
    id_uses_md = id;
    md_busy    = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({md_start, md_op, md_mthi, md_mtlo, hilo_sel, stall_id, md_done, proto_err} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000000",
               {md_start, md_op, md_mthi, md_mtlo, hilo_sel, stall_id, md_done, proto_err});
    end
    tick();
  endtask

  task automatic test_mult();
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      if (c == 0)      drive(1'b1, 4'd1, 1'b1, 1'b0);
      else if (c <= 5) drive(1'b0, 4'd0, 1'b1, 1'b1);
      else if (c == 6) drive(1'b0, 4'd0, 1'b1, 1'b0);
      else             drive(1'b1, 4'd7, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (md_start !== (c == 0)) begin errors++; $display("FAIL mult_start c%0d: got %b expected %b", c, md_start, (c == 0)); end
      checks++;
      if (stall_id !== (c <= 5)) begin errors++; $display("FAIL mult_stall c%0d: got %b expected %b", c, stall_id, (c <= 5)); end
      checks++;
      if (md_done !== (c == 6)) begin errors++; $display("FAIL mult_done c%0d: got %b expected %b", c, md_done, (c == 6)); end
      checks++;
      if (proto_err !== 1'b0) begin errors++; $display("FAIL mult_err c%0d: got %b expected 0", c, proto_err); end
      if (c == 0) begin
        checks++;
        if (md_op !== 2'b00) begin errors++; $display("FAIL mult_op: got %b expected 00", md_op); end
      end
      tick();
    end
  endtask

  task automatic test_divu();
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      if (c == 0)       drive(1'b1, 4'd4, 1'b1, 1'b0);
      else if (c <= 10) drive(1'b0, 4'd0, 1'b1, 1'b1);
      else              drive(1'b0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (md_done !== (c == 11)) begin errors++; $display("FAIL divu_done c%0d: got %b expected %b", c, md_done, (c == 11)); end
      checks++;
      if (stall_id !== (c <= 10)) begin errors++; $display("FAIL divu_stall c%0d: got %b expected %b", c, stall_id, (c <= 10)); end
      checks++;
      if (proto_err !== 1'b0) begin errors++; $display("FAIL divu_err c%0d: got %b expected 0", c, proto_err); end
      if (c == 0) begin
        checks++;
        if ({md_start, md_op} !== 3'b111) begin errors++; $display("FAIL divu_start_op: got %b expected 111", {md_start, md_op}); end
      end
      if (c == 11) begin
        checks++;
        if (dut.cnt !== 4'd10) begin errors++; $display("FAIL divu_cnt: got %0d expected 10", dut.cnt); end
      end
      tick();
    end
  endtask

  task automatic test_short_busy();
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      if (c == 0)      drive(1'b1, 4'd1, 1'b0, 1'b0);
      else if (c <= 4) drive(1'b0, 4'd0, 1'b0, 1'b1);
      else             drive(1'b0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (md_done !== (c == 5)) begin errors++; $display("FAIL short_done c%0d: got %b expected %b", c, md_done, (c == 5)); end
      checks++;
      if (proto_err !== (c >= 6)) begin errors++; $display("FAIL short_err c%0d: got %b expected %b", c, proto_err, (c >= 6)); end
      tick();
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL short_err_clear: got %b expected 0", proto_err); end
    tick();
  endtask

  task automatic test_hilo_moves();
    do_reset();
    drive(1'b0, 4'd6, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (md_mtlo !== 1'b0) begin errors++; $display("FAIL mtlo_invalid: got %b expected 0", md_mtlo); end
    tick();
    drive(1'b1, 4'd6, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if ({md_mtlo, md_mthi, stall_id, md_start} !== 4'b1000) begin
      errors++; $display("FAIL mtlo_valid: got %b expected 1000", {md_mtlo, md_mthi, stall_id, md_start});
    end
    tick();
    drive(1'b1, 4'd5, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if ({md_mthi, md_mtlo, md_done, stall_id} !== 4'b1000) begin
      errors++; $display("FAIL mthi_valid: got %b expected 1000", {md_mthi, md_mtlo, md_done, stall_id});
    end
    tick();
    drive(1'b1, 4'd8, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({hilo_sel, md_done} !== 2'b10) begin errors++; $display("FAIL mflo_sel: got %b expected 10", {hilo_sel, md_done}); end
    tick();
    drive(1'b1, 4'd7, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({hilo_sel, md_done, proto_err} !== 3'b000) begin
      errors++; $display("FAIL mfhi_sel: got %b expected 000", {hilo_sel, md_done, proto_err});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c <= 18; c++) begin
      if (c == 0)       drive(1'b1, 4'd1, 1'b1, 1'b0);
      else if (c <= 5)  drive(1'b0, 4'd0, 1'b1, 1'b1);
      else if (c == 6)  drive(1'b1, 4'd3, 1'b1, 1'b0);
      else if (c <= 16) drive(1'b0, 4'd0, 1'b1, 1'b1);
      else              drive(1'b0, 4'd0, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (md_start !== (c == 0 || c == 6)) begin errors++; $display("FAIL b2b_start c%0d: got %b expected %b", c, md_start, (c == 0 || c == 6)); end
      checks++;
      if (md_done !== (c == 6 || c == 17)) begin errors++; $display("FAIL b2b_done c%0d: got %b expected %b", c, md_done, (c == 6 || c == 17)); end
      checks++;
      if (stall_id !== (c <= 16)) begin errors++; $display("FAIL b2b_stall c%0d: got %b expected %b", c, stall_id, (c <= 16)); end
      checks++;
      if (proto_err !== 1'b0) begin errors++; $display("FAIL b2b_err c%0d: got %b expected 0", c, proto_err); end
      if (c == 6) begin
        checks++;
        if (md_op !== 2'b10) begin errors++; $display("FAIL b2b_op: got %b expected 10", md_op); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      reset = (c == 3);
      if (c == 0)      drive(1'b1, 4'd3, 1'b1, 1'b0);
      else if (c == 2) drive(1'b1, 4'd1, 1'b1, 1'b1);
      else if (c <= 3) drive(1'b0, 4'd0, 1'b1, 1'b1);
      else             drive(1'b0, 4'd0, 1'b1, 1'b0);
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if ({md_start, stall_id} !== 2'b01) begin errors++; $display("FAIL rmid_suppress: got %b expected 01", {md_start, stall_id}); end
      end
      if (c == 3) begin
        checks++;
        if (proto_err !== 1'b1) begin errors++; $display("FAIL rmid_err_set: got %b expected 1", proto_err); end
      end
      if (c == 4) begin
        checks++;
        if ({dut.st, stall_id, md_done, proto_err} !== 4'b0000) begin
          errors++; $display("FAIL rmid_after: got %b expected 0000", {dut.st, stall_id, md_done, proto_err});
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  // Reference model: an operation is "in flight" from its start until the
  // unit's busy flag drops; the busy cycles seen must equal the latency.
  task automatic test_random();
    bit in_flight = 0;
    int n_busy = 0;
    int lat = 0;
    bit m_err = 0;
    int unit_rem = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit rst_now, stray, bsy, blk, is_md, e_start, e_mthi, e_mtlo, e_hilo, e_stall, e_done;
      logic [1:0] e_op;
      int op_i;
      rst_now = ($urandom_range(0, 199) == 0) || (m_err && $urandom_range(0, 29) == 0);
      stray = (unit_rem == 0) && ($urandom_range(0, 99) == 0);
      bsy = (unit_rem > 0) || stray;
      blk = in_flight && bsy;
      if (blk && $urandom_range(0, 39) != 0)
        op_i = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(7, 15));
      else
        op_i = int'($urandom_range(0, 15));
      reset = rst_now;
      drive(1'($urandom_range(0, 1)), 4'(op_i), 1'($urandom_range(0, 1)), bsy);
      @(negedge clk);

      is_md   = (op_i >= 1 && op_i <= 4);
      e_start = ex_valid && is_md && !blk;
      e_op    = is_md ? 2'(op_i - 1) : 2'b00;
      e_mthi  = ex_valid && op_i == 5 && !blk;
      e_mtlo  = ex_valid && op_i == 6 && !blk;
      e_hilo  = (op_i == 8);
      e_stall = id_uses_md && (e_start || blk);
      e_done  = in_flight && !bsy;

      checks++;
      if ({md_start, md_op} !== {e_start, e_op}) begin
        errors++; $display("FAIL rand_start i%0d: got %b expected %b", i, {md_start, md_op}, {e_start, e_op});
      end
      checks++;
      if ({md_mthi, md_mtlo, hilo_sel} !== {e_mthi, e_mtlo, e_hilo}) begin
        errors++; $display("FAIL rand_moves i%0d: got %b expected %b", i, {md_mthi, md_mtlo, hilo_sel}, {e_mthi, e_mtlo, e_hilo});
      end
      checks++;
      if ({stall_id, md_done} !== {e_stall, e_done}) begin
        errors++; $display("FAIL rand_stall_done i%0d: got %b expected %b", i, {stall_id, md_done}, {e_stall, e_done});
      end
      checks++;
      if (proto_err !== m_err) begin
        errors++; $display("FAIL rand_err i%0d: got %b expected %b", i, proto_err, m_err);
      end

      if (rst_now) begin
        in_flight = 0; n_busy = 0; lat = 0; m_err = 0; unit_rem = 0;
      end else begin
        if (!in_flight && bsy) m_err = 1;
        if (blk && ex_valid && op_i >= 1 && op_i <= 6) m_err = 1;
        if (blk) begin
          n_busy++;
          if (n_busy > lat) m_err = 1;
        end
        if (e_done) begin
          if (n_busy != lat) m_err = 1;
          in_flight = 0;
        end
        if (unit_rem > 0) unit_rem--;
        if (e_start) begin
          in_flight = 1;
          n_busy = 0;
          lat = (op_i <= 2) ? 5 : 10;
          unit_rem = lat;
          if ($urandom_range(0, 19) == 0)
            unit_rem = ($urandom_range(0, 1) == 0) ? lat - 1 : lat + 1;
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    test_reset();
    test_mult();
    test_divu();
    test_short_busy();
    test_hilo_moves();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
